serial_operand_loader: RTL and testbench
========================================

# serial_operand_loader

Parametrised serial-to-parallel operand loader that drives a compressor under test. Each of `CHANNELS` serial inputs shifts into its own `WIDTH`-bit register. In framed mode a bit counter marks word boundaries and captures all channels into a holding register, so the compressor sees stable operands plus a one-cycle `valid` pulse. Continuous mode is also available, in which the operands track the shift registers every cycle. Sits between the bench's serial stimulus pins and the compressor's `src*` operand inputs.

## Interface
Parameters:
- `CHANNELS`, 26, number of serial inputs / compressor operands (≥1)
- `WIDTH`, 26, bits per operand (≥2)
- `MSB_FIRST`, 1: 1 = first received bit ends at operand MSB (shift left, new bit into bit 0); 0 = first bit ends at LSB (shift right, new bit into bit `WIDTH-1`)
- `CONTINUOUS`, 0: 1 = `operands` mirrors shift registers every cycle, no framing; 0 = framed capture

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `shift_en`  in  1  shift all channels by one bit this cycle
- `clear`  in  1  synchronous clear of shift registers and bit counter
- `src_`  in  `CHANNELS`  serial bits, bit c feeds channel c
- `operands`  out  `CHANNELS*WIDTH`  operand c at `[c*WIDTH +: WIDTH]`
- `valid`  out  1  one-cycle pulse: new framed word captured (always 0 when `CONTINUOUS`=1)
- `bit_cnt`  out  `$clog2(WIDTH+1)`  bits shifted into current frame, range 0..`WIDTH-1`
- `frames`  out  16  count of captured frames, saturates at 16'hFFFF

## Operation
- Reset (`rst`=1, async): all shift regs, holding reg, `operands`, `valid`, `bit_cnt`, `frames` = 0.
- Shift (`shift_en`=1, `clear`=0): every channel shifts per `MSB_FIRST`. `bit_cnt` increments.
- Frame completion (framed mode): on an edge with `shift_en`=1, `clear`=0, `bit_cnt`==`WIDTH-1`:
  - holding reg ← post-shift value of all shift regs (includes this cycle's bit)
  - `valid` ← 1, `bit_cnt` ← 0, `frames` ← `frames`+1 (saturating)
- `valid` is otherwise 0; never high two consecutive cycles unless frames complete back to back, which needs `WIDTH` shifts, so never for `WIDTH`≥2.
- `shift_en`=0: shift regs and `bit_cnt` hold; holding reg holds; `valid`=0.
- `clear`=1: shift regs ← 0, `bit_cnt` ← 0. Holding reg, `frames` unchanged. `clear` beats `shift_en`, including on the completion cycle (no capture, no `valid`).
- Framed mode: `operands` = holding reg; changes only on capture edges.
- Continuous mode: `operands` = shift regs. `bit_cnt` still counts and wraps at `WIDTH`. `valid` stays 0 and `frames` stays 0.
- Shift regs are not reset between frames. A new frame overwrites them fully after `WIDTH` shifts.

## Timing
- Shift latency: a bit on `src_` at edge k is in the shift reg after edge k.
- Framed: the word is visible on `operands` and `valid`=1 in the cycle after the `WIDTH`-th shift edge, and `operands` stays stable until the next capture.
- Continuous: `operands` updates in the cycle after each shift edge, as in the legacy free-running loader.
- `rst` asserted mid-frame clears immediately (async). Deassertion is taken synchronously by the bench; the first shift after release counts as bit 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: `CHANNELS`=2, `WIDTH`=4, assert `rst` mid-frame after 2 shifts → `operands`=0, `bit_cnt`=0, `valid`=0, `frames`=0 with no clock edge.
- Framed MSB-first: ch0 stream 1,0,1,1 and ch1 stream 0,1,1,0 on 4 consecutive `shift_en` cycles → next cycle `valid`=1, `operands`=8'h6B (ch1=4'h6, ch0=4'hB), `frames`=1; `valid`=0 the cycle after.
- LSB-first: `MSB_FIRST`=0, same streams → ch0=4'hD, ch1=4'h6, `operands`=8'h6D.
- Gaps and clear: insert `shift_en`=0 cycles mid-frame → `bit_cnt` holds and the capture still happens after the 4th shift. Assert `clear` together with the 4th shift → no `valid`, `bit_cnt`=0, `operands` keeps the previous word.
- Continuous: `CONTINUOUS`=1, shift ch0 1,1,0 → ch0 of `operands` reads 4'h1, 4'h3, 4'h6 on successive cycles; `valid` stays 0.
- Saturation: force 65 536 frames (`WIDTH`=2) → `frames` stops at 16'hFFFF and operand capture continues normally.

Source files
------------

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: per-channel serial shift registers feeding compressor operands,
// either captured per WIDTH-bit frame into a holding register or mirrored continuously.
module serial_operand_loader #(
    parameter int CHANNELS   = 26,
    parameter int WIDTH      = 26,
    parameter int MSB_FIRST  = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shift_en,
    input  logic                          clear,
    input  logic [CHANNELS-1:0]           src_,
    output logic [CHANNELS*WIDTH-1:0]     operands,
    output logic                          valid,
    output logic [$clog2(WIDTH+1)-1:0]    bit_cnt,
    output logic [15:0]                   frames
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [CHANNELS*WIDTH-1:0] sr, sr_next, hold;
    logic last;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign sr_next[c*WIDTH +: WIDTH] = (MSB_FIRST != 0)
            ? {sr[c*WIDTH +: WIDTH-1], src_[c]}
            : {src_[c], sr[c*WIDTH+1 +: WIDTH-1]};
    end
    assign last = bit_cnt == CW'(WIDTH - 1);
    assign operands = (CONTINUOUS != 0) ? sr : hold;
    // clear has priority over shift_en, so a clear on the completion edge suppresses capture
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sr      <= '0;
            hold    <= '0;
            valid   <= 1'b0;
            bit_cnt <= '0;
            frames  <= '0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                sr      <= sr_next;
                bit_cnt <= last ? '0 : bit_cnt + CW'(1);
                if (last && CONTINUOUS == 0) begin
                    hold   <= sr_next;
                    valid  <= 1'b1;
                    frames <= frames + 16'(frames != 16'hFFFF);
                end
            end
        end
endmodule

// File: tb/tb_serial_operand_loader.sv
// tb_serial_operand_loader: directed checks of framed MSB/LSB, continuous and saturating
// loader instances, all driven from one shared 2-channel serial stimulus.
module tb_serial_operand_loader;
    logic clk = 1'b0, rst = 1'b0, shift_en = 1'b0, clear = 1'b0;
    logic [1:0] src = 2'b00;
    logic [7:0] m_ops, l_ops, c_ops;
    logic [3:0] s_ops;
    logic m_valid, l_valid, c_valid, s_valid;
    logic [2:0] m_cnt, l_cnt, c_cnt;
    logic [1:0] s_cnt;
    logic [15:0] m_frames, l_frames, c_frames, s_frames;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    serial_operand_loader #(.CHANNELS(2), .WIDTH(4), .MSB_FIRST(1), .CONTINUOUS(0)) dut_m (
        .clk(clk), .rst(rst), .shift_en(shift_en), .clear(clear), .src_(src),
        .operands(m_ops), .valid(m_valid), .bit_cnt(m_cnt), .frames(m_frames));
    serial_operand_loader #(.CHANNELS(2), .WIDTH(4), .MSB_FIRST(0), .CONTINUOUS(0)) dut_l (
        .clk(clk), .rst(rst), .shift_en(shift_en), .clear(clear), .src_(src),
        .operands(l_ops), .valid(l_valid), .bit_cnt(l_cnt), .frames(l_frames));
    serial_operand_loader #(.CHANNELS(2), .WIDTH(4), .MSB_FIRST(1), .CONTINUOUS(1)) dut_c (
        .clk(clk), .rst(rst), .shift_en(shift_en), .clear(clear), .src_(src),
        .operands(c_ops), .valid(c_valid), .bit_cnt(c_cnt), .frames(c_frames));
    serial_operand_loader #(.CHANNELS(2), .WIDTH(2), .MSB_FIRST(1), .CONTINUOUS(0)) dut_s (
        .clk(clk), .rst(rst), .shift_en(shift_en), .clear(clear), .src_(src),
        .operands(s_ops), .valid(s_valid), .bit_cnt(s_cnt), .frames(s_frames));

    // s = {ch1, ch0}; outputs are sampled 1 ns after the edge
    task automatic step(input logic en, input logic clr, input logic [1:0] s);
        shift_en = en;
        clear = clr;
        src = s;
        @(posedge clk);
        #1;
        shift_en = 1'b0;
        clear = 1'b0;
        src = 2'b00;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (m_ops !== 8'h00) begin failures++; $display("FAIL reset_ops got=%h exp=00", m_ops); end
        checks++; if (m_valid !== 1'b0 || m_cnt !== 3'd0) begin failures++; $display("FAIL reset_valid_cnt got=%b/%0d exp=0/0", m_valid, m_cnt); end
        checks++; if (m_frames !== 16'd0 || s_frames !== 16'd0) begin failures++; $display("FAIL reset_frames got=%h/%h exp=0/0", m_frames, s_frames); end
        rst = 1'b0;
    endtask

    task automatic test_continuous;
        step(1'b1, 1'b0, 2'b01);
        checks++; if (c_ops[3:0] !== 4'h1) begin failures++; $display("FAIL cont_ops1 got=%h exp=1", c_ops[3:0]); end
        step(1'b1, 1'b0, 2'b01);
        checks++; if (c_ops[3:0] !== 4'h3) begin failures++; $display("FAIL cont_ops2 got=%h exp=3", c_ops[3:0]); end
        step(1'b1, 1'b0, 2'b00);
        checks++; if (c_ops[3:0] !== 4'h6) begin failures++; $display("FAIL cont_ops3 got=%h exp=6", c_ops[3:0]); end
        checks++; if (c_cnt !== 3'd3) begin failures++; $display("FAIL cont_cnt3 got=%0d exp=3", c_cnt); end
        step(1'b1, 1'b0, 2'b01);
        checks++; if (c_ops !== 8'h0D || c_cnt !== 3'd0) begin failures++; $display("FAIL cont_wrap got=%h/%0d exp=0d/0", c_ops, c_cnt); end
        checks++; if (c_valid !== 1'b0 || c_frames !== 16'd0) begin failures++; $display("FAIL cont_noframe got=%b/%0d exp=0/0", c_valid, c_frames); end
        checks++; if (m_valid !== 1'b1 || m_ops !== 8'h0D) begin failures++; $display("FAIL cont_framed_side got=%b/%h exp=1/0d", m_valid, m_ops); end
    endtask

    task automatic test_framed;
        step(1'b1, 1'b0, 2'b01);
        checks++; if (m_valid !== 1'b0 || m_ops !== 8'h0D) begin failures++; $display("FAIL framed_hold got=%b/%h exp=0/0d", m_valid, m_ops); end
        step(1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b0, 2'b01);
        checks++; if (m_valid !== 1'b1 || m_ops !== 8'h6B) begin failures++; $display("FAIL framed_msb got=%b/%h exp=1/6b", m_valid, m_ops); end
        checks++; if (m_frames !== 16'd2 || m_cnt !== 3'd0) begin failures++; $display("FAIL framed_frames got=%0d/%0d exp=2/0", m_frames, m_cnt); end
        checks++; if (l_valid !== 1'b1 || l_ops !== 8'h6D) begin failures++; $display("FAIL framed_lsb got=%b/%h exp=1/6d", l_valid, l_ops); end
        step(1'b0, 1'b0, 2'b11);
        checks++; if (m_valid !== 1'b0 || m_ops !== 8'h6B) begin failures++; $display("FAIL framed_after got=%b/%h exp=0/6b", m_valid, m_ops); end
    endtask

    task automatic test_gaps_clear;
        step(1'b1, 1'b0, 2'b10);
        step(1'b0, 1'b0, 2'b11);
        checks++; if (m_cnt !== 3'd1) begin failures++; $display("FAIL gap_cnt1 got=%0d exp=1", m_cnt); end
        step(1'b1, 1'b0, 2'b11);
        step(1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b0, 2'b01);
        checks++; if (m_cnt !== 3'd2 || m_valid !== 1'b0) begin failures++; $display("FAIL gap_cnt2 got=%0d/%b exp=2/0", m_cnt, m_valid); end
        step(1'b1, 1'b0, 2'b10);
        step(1'b0, 1'b0, 2'b00);
        checks++; if (m_cnt !== 3'd3 || m_ops !== 8'h6B) begin failures++; $display("FAIL gap_cnt3 got=%0d/%h exp=3/6b", m_cnt, m_ops); end
        step(1'b1, 1'b0, 2'b10);
        checks++; if (m_valid !== 1'b1 || m_ops !== 8'hF4 || l_ops !== 8'hF2) begin failures++; $display("FAIL gap_capture got=%b/%h/%h exp=1/f4/f2", m_valid, m_ops, l_ops); end
        step(1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b1, 2'b01);
        checks++; if (m_valid !== 1'b0 || m_cnt !== 3'd0) begin failures++; $display("FAIL clear_last got=%b/%0d exp=0/0", m_valid, m_cnt); end
        checks++; if (m_ops !== 8'hF4 || m_frames !== 16'd3) begin failures++; $display("FAIL clear_hold got=%h/%0d exp=f4/3", m_ops, m_frames); end
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        checks++; if (m_cnt !== 3'd3 || m_valid !== 1'b0) begin failures++; $display("FAIL clear_restart got=%0d/%b exp=3/0", m_cnt, m_valid); end
        step(1'b1, 1'b0, 2'b01);
        checks++; if (m_ops !== 8'h01 || l_ops !== 8'h08 || m_frames !== 16'd4) begin failures++; $display("FAIL clear_next got=%h/%h/%0d exp=01/08/4", m_ops, l_ops, m_frames); end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 1'b0, 2'b11);
        step(1'b1, 1'b0, 2'b11);
        checks++; if (m_cnt !== 3'd2) begin failures++; $display("FAIL midrst_pre got=%0d exp=2", m_cnt); end
        rst = 1'b1;
        #2;
        checks++; if (m_ops !== 8'h00 || m_cnt !== 3'd0) begin failures++; $display("FAIL midrst_async got=%h/%0d exp=00/0", m_ops, m_cnt); end
        checks++; if (m_valid !== 1'b0 || m_frames !== 16'd0) begin failures++; $display("FAIL midrst_flags got=%b/%0d exp=0/0", m_valid, m_frames); end
        rst = 1'b0;
        step(1'b1, 1'b0, 2'b00);
        checks++; if (m_cnt !== 3'd1) begin failures++; $display("FAIL midrst_bit0 got=%0d exp=1", m_cnt); end
    endtask

    task automatic test_saturation;
        step(1'b0, 1'b1, 2'b00);
        force dut_s.frames = 16'hFFFD;
        #1;
        release dut_s.frames;
        step(1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 2'b10);
        checks++; if (s_frames !== 16'hFFFE || s_ops !== 4'h6) begin failures++; $display("FAIL sat_fffe got=%h/%h exp=fffe/6", s_frames, s_ops); end
        step(1'b1, 1'b0, 2'b10);
        step(1'b1, 1'b0, 2'b11);
        checks++; if (s_frames !== 16'hFFFF || s_ops !== 4'hD) begin failures++; $display("FAIL sat_ffff got=%h/%h exp=ffff/d", s_frames, s_ops); end
        step(1'b1, 1'b0, 2'b01);
        step(1'b1, 1'b0, 2'b01);
        checks++; if (s_frames !== 16'hFFFF || s_ops !== 4'h3 || s_valid !== 1'b1) begin failures++; $display("FAIL sat_hold got=%h/%h/%b exp=ffff/3/1", s_frames, s_ops, s_valid); end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_continuous;
        test_framed;
        test_gaps_clear;
        test_reset_mid;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
